// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle controller
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LUI    = 4'd1,
    CLS_AUIPC  = 4'd2,
    CLS_JAL    = 4'd3,
    CLS_JALR   = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_LOAD   = 4'd6,
    CLS_STORE  = 4'd7,
    CLS_OPIMM  = 4'd8,
    CLS_OP     = 4'd9
  } op_class_t;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_TARGET = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_UIMM = 2'd3;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - maps an RV32I major opcode to its class and an illegal flag
module opcode_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [3:0] class_o,
  output logic       illegal_o
);

  // Pure lookup; anything outside the supported base set is flagged illegal
  always_comb begin
    class_o   = CLS_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_LUI:    class_o = CLS_LUI;
      OPC_AUIPC:  class_o = CLS_AUIPC;
      OPC_JAL:    class_o = CLS_JAL;
      OPC_JALR:   class_o = CLS_JALR;
      OPC_BRANCH: class_o = CLS_BRANCH;
      OPC_LOAD:   class_o = CLS_LOAD;
      OPC_STORE:  class_o = CLS_STORE;
      OPC_OPIMM:  class_o = CLS_OPIMM;
      OPC_OP:     class_o = CLS_OP;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_WIDTH = 32,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [31:0]              instruction_i,
  input  logic                     branch_taken_i,
  input  logic                     mem_ready_i,
  output logic                     write_pc_o,
  output logic                     write_ir_o,
  output logic                     write_reg_file_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [1:0]               pc_sel_o,
  output logic                     alu_b_sel_o,
  output logic [1:0]               wb_sel_o,
  output logic [2:0]               state_o,
  output logic                     trap_o,
  output logic [1:0]               trap_cause_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  state_t                   r_state;
  op_class_t                r_class;
  logic [7:0]               r_tmo_cnt;
  logic                     r_trap;
  logic [1:0]               r_cause;
  logic [INSTRET_WIDTH-1:0] r_instret;

  logic [3:0]               w_dec_class;
  logic                     w_dec_illegal;
  logic [7:0]               w_tmo_next;
  logic [INSTRET_WIDTH-1:0] w_instret_next;
  logic                     w_rd_nonzero;
  logic                     w_unused;

  opcode_decoder u_opcode_decoder (
    .opcode_i  (instruction_i[6:0]),
    .class_o   (w_dec_class),
    .illegal_o (w_dec_illegal)
  );

  assign w_tmo_next     = r_tmo_cnt + 8'd1;
  assign w_instret_next = r_instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
  assign w_rd_nonzero   = (instruction_i[11:7] != 5'd0);
  assign w_unused       = ^instruction_i[31:12];

  assign state_o      = r_state;
  assign trap_o       = r_trap;
  assign trap_cause_o = r_cause;
  assign instret_o    = r_instret;

  // State sequencing, class latch, memory timeout, retire count and sticky trap
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= ST_BOOT;
      r_class   <= CLS_NONE;
      r_tmo_cnt <= 8'd0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      case (r_state)
        ST_BOOT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_class <= op_class_t'(w_dec_class);
          if (w_dec_illegal) begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_ILLEGAL;
          end else begin
            r_state <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          case (r_class)
            CLS_BRANCH: begin
              r_instret <= w_instret_next;
              r_state   <= ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: begin
              r_tmo_cnt <= 8'd0;
              r_state   <= ST_MEM;
            end
            default: r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEM: begin
          // Ready wins over timeout when both land on the same cycle
          if (mem_ready_i) begin
            if (r_class == CLS_STORE) begin
              r_instret <= w_instret_next;
              r_state   <= ST_FETCH;
            end else begin
              r_state <= ST_WRITEBACK;
            end
          end else begin
            r_tmo_cnt <= w_tmo_next;
            if (w_tmo_next == MEM_TIMEOUT[7:0]) begin
              r_state <= ST_TRAP;
              r_trap  <= 1'b1;
              r_cause <= CAUSE_MEM_TIMEOUT;
            end
          end
        end
        ST_WRITEBACK: begin
          r_instret <= w_instret_next;
          r_state   <= ST_FETCH;
        end
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // Strobes and selects decoded from current state and latched opcode class
  always_comb begin
    write_pc_o       = 1'b0;
    write_ir_o       = 1'b0;
    write_reg_file_o = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    pc_sel_o         = PC_SEL_PLUS4;
    alu_b_sel_o      = 1'b0;
    wb_sel_o         = WB_SEL_ALU;
    case (r_state)
      ST_FETCH: write_ir_o = 1'b1;
      ST_EXECUTE: begin
        alu_b_sel_o = (r_class == CLS_OPIMM) || (r_class == CLS_LOAD) ||
                      (r_class == CLS_STORE) || (r_class == CLS_JALR);
        if (r_class == CLS_BRANCH) begin
          write_pc_o = 1'b1;
          pc_sel_o   = branch_taken_i ? PC_SEL_TARGET : PC_SEL_PLUS4;
        end
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (r_class == CLS_STORE);
        if (mem_ready_i && (r_class == CLS_STORE)) begin
          write_pc_o = 1'b1;
          pc_sel_o   = PC_SEL_PLUS4;
        end
      end
      ST_WRITEBACK: begin
        write_reg_file_o = w_rd_nonzero;
        write_pc_o       = 1'b1;
        case (r_class)
          CLS_LUI:  wb_sel_o = WB_SEL_UIMM;
          CLS_LOAD: wb_sel_o = WB_SEL_LOAD;
          CLS_JAL: begin
            wb_sel_o = WB_SEL_PC4;
            pc_sel_o = PC_SEL_TARGET;
          end
          CLS_JALR: begin
            wb_sel_o = WB_SEL_PC4;
            pc_sel_o = PC_SEL_JALR;
          end
          default: wb_sel_o = WB_SEL_ALU;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int IW  = 4;
  localparam int TMO = 16;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic [31:0]   instruction_i = 32'h0;
  logic          branch_taken_i = 1'b0;
  logic          mem_ready_i = 1'b0;
  logic          write_pc_o, write_ir_o, write_reg_file_o, mem_req_o, mem_we_o;
  logic [1:0]    pc_sel_o, wb_sel_o, trap_cause_o;
  logic          alu_b_sel_o, trap_o;
  logic [2:0]    state_o;
  logic [IW-1:0] instret_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [IW-1:0] exp_instret = '0;

  multicycle_controller #(.INSTRET_WIDTH(IW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .instruction_i    (instruction_i),
    .branch_taken_i   (branch_taken_i),
    .mem_ready_i      (mem_ready_i),
    .write_pc_o       (write_pc_o),
    .write_ir_o       (write_ir_o),
    .write_reg_file_o (write_reg_file_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .pc_sel_o         (pc_sel_o),
    .alu_b_sel_o      (alu_b_sel_o),
    .wb_sel_o         (wb_sel_o),
    .state_o          (state_o),
    .trap_o           (trap_o),
    .trap_cause_o     (trap_cause_o),
    .instret_o        (instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instruction classes as named by the ISA, 0 = not a supported opcode
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110111: return 1;  // LUI
      7'b0010111: return 2;  // AUIPC
      7'b1101111: return 3;  // JAL
      7'b1100111: return 4;  // JALR
      7'b1100011: return 5;  // BRANCH
      7'b0000011: return 6;  // LOAD
      7'b0100011: return 7;  // STORE
      7'b0010011: return 8;  // OPIMM
      7'b0110011: return 9;  // OP
      default:    return 0;
    endcase
  endfunction

  function automatic logic [6:0] legal_op(input int k);
    logic [6:0] tbl [9];
    tbl = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    return tbl[k];
  endfunction

  function automatic logic [2:0] all_strobes();
    return {write_pc_o | write_ir_o, write_reg_file_o, mem_req_o | mem_we_o};
  endfunction

  // Asserts reset, checks the cleared state, releases, returns at the FETCH negedge
  task automatic do_reset();
    reset_i = 1'b0;
    #1;
    check_val("rst_state", state_o, 0);
    check_val("rst_instret", instret_o, 0);
    check_val("rst_trap", trap_o, 0);
    check_val("rst_cause", trap_cause_o, 0);
    check_val("rst_strobes", {all_strobes(), pc_sel_o, wb_sel_o, alu_b_sel_o}, 0);
    exp_instret = '0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check_val("boot_state", state_o, 0);
    check_val("boot_strobes", all_strobes(), 0);
    @(negedge clk_i);
  endtask

  // Runs one legal instruction starting at FETCH and checks its aggregate behaviour
  task automatic run_instr(input logic [31:0] ins, input bit taken, input int nwait);
    int cyc = 0, wir = 0, wpc = 0, req = 0, we = 0, wrf = 0, absel = 0;
    int c, e_lat, e_req, e_we, e_wrf, e_ab, e_pcs, e_wbs;
    logic [1:0] pcs = 2'd0, wbs = 2'd0;
    logic [IW-1:0] start;
    bit done = 0;
    start = instret_o;
    instruction_i  = ins;
    branch_taken_i = taken;
    while (!done) begin
      mem_ready_i = mem_req_o && (req >= nwait);
      #1;
      if (cyc == 0) check_val("start_fetch", state_o, 1);
      if (instret_o != start || trap_o || cyc > 300) begin
        done = 1;
      end else begin
        cyc++;
        wir   += int'(write_ir_o);
        wpc   += int'(write_pc_o);
        req   += int'(mem_req_o);
        we    += int'(mem_we_o);
        wrf   += int'(write_reg_file_o);
        absel += int'(alu_b_sel_o);
        if (write_pc_o) begin
          pcs = pc_sel_o;
          wbs = wb_sel_o;
        end
        @(negedge clk_i);
      end
    end
    mem_ready_i = 1'b0;
    c = cls_of(ins[6:0]);
    e_lat = (c == 5) ? 4 : (c == 7) ? 5 + nwait : (c == 6) ? 6 + nwait : 5;
    e_req = (c == 6 || c == 7) ? nwait + 1 : 0;
    e_we  = (c == 7) ? nwait + 1 : 0;
    e_wrf = (c != 5 && c != 7 && ins[11:7] != 5'd0) ? 1 : 0;
    e_ab  = (c == 8 || c == 6 || c == 7 || c == 4) ? 1 : 0;
    e_pcs = (c == 3) ? 1 : (c == 4) ? 2 : (c == 5 && taken) ? 1 : 0;
    e_wbs = (c == 1) ? 3 : (c == 6) ? 1 : (c == 3 || c == 4) ? 2 : 0;
    exp_instret = exp_instret + 1'b1;
    check_val($sformatf("latency_cls%0d", c), cyc + 1, e_lat);
    check_val("write_ir_pulses", wir, 1);
    check_val("write_pc_pulses", wpc, 1);
    check_val("mem_req_cycles", req, e_req);
    check_val("mem_we_cycles", we, e_we);
    check_val("write_rf_pulses", wrf, e_wrf);
    check_val("alu_b_sel_cycles", absel, e_ab);
    check_val("pc_sel", pcs, e_pcs);
    check_val("wb_sel", wbs, e_wbs);
    check_val("instret", instret_o, exp_instret);
    check_val("next_fetch", state_o, 1);
    check_val("no_trap", trap_o, 0);
  endtask

  initial begin
    logic [31:0] ins;
    int          wait_n, cyc, req, we, stray;
    logic [6:0]  op;

    @(negedge clk_i);
    do_reset();

    // LUI x5,0x12345 right out of reset
    run_instr(32'h123452B7, 1'b0, 0);
    // BEQ taken then not taken
    run_instr(32'h00208463, 1'b1, 0);
    run_instr(32'h00208463, 1'b0, 0);
    check_val("instret_after_beq", instret_o, 3);
    // LW with three wait cycles, and ready exactly on the timeout cycle
    run_instr(32'h0000A283, 1'b0, 3);
    run_instr(32'h0050A023, 1'b0, TMO - 1);
    run_instr(32'h0000A303, 1'b0, TMO - 1);

    // Random legal instructions; instret wraps at 2^IW along the way
    for (int i = 0; i < 40; i++) begin
      ins = $urandom();
      ins[6:0] = legal_op(int'($urandom_range(0, 8)));
      if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
      case ($urandom_range(0, 3))
        0: wait_n = 0;
        1: wait_n = TMO - 1;
        default: wait_n = int'($urandom_range(0, TMO - 1));
      endcase
      run_instr(ins, 1'($urandom_range(0, 1)), wait_n);
    end

    // Illegal opcodes: 1111111 plus a random unsupported one
    for (int k = 0; k < 2; k++) begin
      do_reset();
      op = 7'b1111111;
      if (k == 1) begin
        op = 7'($urandom());
        while (cls_of(op) != 0) op = 7'($urandom());
      end
      instruction_i = {$urandom_range(0, 32'hFFFFF), 5'd3, op};
      cyc = 0;
      #1;
      while (!trap_o && cyc < 50) begin
        cyc++;
        @(negedge clk_i);
        #1;
      end
      check_val("illegal_cycles", cyc, 2);
      check_val("illegal_cause", trap_cause_o, 1);
      check_val("illegal_state", state_o, 6);
      check_val("illegal_instret", instret_o, 0);
      @(negedge clk_i);
    end

    // ADDI x0,x0,1: no register write but the PC still advances
    do_reset();
    run_instr(32'h00100013, 1'b0, 0);

    // SW that never gets ready -> memory timeout trap
    do_reset();
    instruction_i = 32'h0050A023;
    mem_ready_i   = 1'b0;
    cyc = 0; req = 0; we = 0;
    #1;
    while (!trap_o && cyc < 200) begin
      cyc++;
      req += int'(mem_req_o);
      we  += int'(mem_we_o);
      @(negedge clk_i);
      #1;
    end
    check_val("tmo_req_cycles", req, TMO);
    check_val("tmo_we_cycles", we, TMO);
    check_val("tmo_cause", trap_cause_o, 2);
    check_val("tmo_state", state_o, 6);
    stray = 0;
    for (int t = 0; t < 100; t++) begin
      mem_ready_i    = 1'($urandom_range(0, 1));
      branch_taken_i = 1'($urandom_range(0, 1));
      instruction_i  = $urandom();
      #1;
      if (all_strobes() != 0 || state_o != 3'd6 || !trap_o || trap_cause_o != 2'd2) stray++;
      @(negedge clk_i);
    end
    check_val("trap_absorbing", stray, 0);
    mem_ready_i = 1'b0;

    // Reset asserted asynchronously in the middle of a LOAD's MEM phase
    do_reset();
    run_instr(32'h00100093, 1'b0, 0);
    instruction_i = 32'h0000A283;
    mem_ready_i   = 1'b0;
    repeat (4) @(negedge clk_i);
    #1;
    check_val("mid_mem_req", mem_req_o, 1);
    check_val("mid_mem_instret", instret_o, 1);
    #1;
    reset_i = 1'b0;
    #1;
    check_val("async_req_drop", mem_req_o, 0);
    check_val("async_state", state_o, 0);
    check_val("async_instret", instret_o, 0);
    check_val("async_trap", trap_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check_val("restart_boot", state_o, 0);
    @(negedge clk_i);
    #1;
    check_val("restart_fetch", state_o, 1);
    check_val("restart_ir", write_ir_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
